// File: rtl/ripple_count_pkg.sv
// ----------------------------------------------------------------------------
// ripple_count_pkg
// Shared definitions for the ripple counter monitor: monitor FSM state type
// and default width/filter constants used as parameter defaults.
// ----------------------------------------------------------------------------
package ripple_count_pkg;

  localparam int unsigned W_DEF             = 3;
  localparam int unsigned STABLE_CYCLES_DEF = 2;
  localparam int unsigned ERR_CNT_W_DEF     = 8;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// W-bit two-flop synchronizer; q is d delayed by two clk edges.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high; clears both flop stages
//   d     - asynchronous input bits
//   q     - synchronized output bits
// ----------------------------------------------------------------------------
module sync_2ff
  import ripple_count_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// ----------------------------------------------------------------------------
// ripple_count_monitor
// Consumer of an asynchronous ripple counter. Synchronizes the raw bits,
// filters ripple transients, and publishes a clean committed count with a
// commit strobe, a terminal-wrap pulse and an optional step-sequence checker.
//
// Build option: define RCM_STEP_CHECK_EN to include the step checker
// (step_err, err_cnt). Without it both outputs are tied to zero.
//
// Ports:
//   clk         - system clock (must exceed 4x the ripple source clock)
//   reset       - asynchronous, active-high; clears all state
//   cnt_in      - raw ripple counter bits, asynchronous, may glitch
//   dir_up      - expected direction: 0 = down, 1 = up (quasi-static)
//   count_out   - last committed count
//   count_valid - one-cycle pulse when count_out updates
//   wrap        - one-cycle pulse with count_valid on a terminal wrap
//   step_err    - one-cycle pulse with count_valid on a bad step
//   err_cnt     - saturating count of step errors
// ----------------------------------------------------------------------------
module ripple_count_monitor
  import ripple_count_pkg::*;
#(
  parameter int unsigned W             = W_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned ERR_CNT_W     = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         cnt_in,
  input  logic                 dir_up,
  output logic [W-1:0]         count_out,
  output logic                 count_valid,
  output logic                 wrap,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  logic [W-1:0] sync_q;
  state_t       state, state_d;
  logic [W-1:0] cand, cand_d;
  logic [3:0]   stab, stab_d;
  logic         commit;
  logic         wrap_d;

  sync_2ff #(
    .W(W)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_in),
    .q     (sync_q)
  );

  // Stability filter. The "candidate equals committed value" test comes
  // first in SETTLE so a glitch that returns to the committed value is
  // dropped instead of being counted up and re-committed.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    stab_d  = stab;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (sync_q != count_out) begin
          cand_d  = sync_q;
          stab_d  = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cand == count_out) begin
          state_d = IDLE;
        end else if (sync_q != cand) begin
          cand_d = sync_q;
          stab_d = '0;
        end else if (stab == STAB_LAST) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          stab_d = stab + 4'd1;
        end
      end
    endcase
  end

  // Wrap is judged against the count being replaced.
  always_comb begin
    if (dir_up) wrap_d = (count_out == '1) && (cand == '0);
    else        wrap_d = (count_out == '0) && (cand == '1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand        <= '0;
      stab        <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      cand        <= cand_d;
      stab        <= stab_d;
      count_valid <= commit;
      wrap        <= commit & wrap_d;
      if (commit) count_out <= cand;
    end
  end

`ifdef RCM_STEP_CHECK_EN
  logic         primed;
  logic [W-1:0] exp_step;

  always_comb begin
    exp_step = dir_up ? count_out + W'(1) : count_out - W'(1);
  end

  // The first commit after reset has no trustworthy predecessor, so it only
  // arms the checker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed   <= 1'b0;
      step_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step_err <= 1'b0;
      if (commit) begin
        primed <= 1'b1;
        if (primed && (cand != exp_step)) begin
          step_err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end
`else
  assign step_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous ripple down counter.
- Brings the raw ripple bits (`cnt_in`) into the `clk` domain through a 2-FF synchronizer, then filters out ripple transients with a stability filter.
- Publishes a clean registered count, a one-cycle commit strobe, a wrap pulse, and a step-sequence error checker with a saturating error counter.

Parameters:
- W, 3: width of the monitored counter.
- STABLE_CYCLES, 2: consecutive identical synchronized samples required after the load sample before a value is committed. Legal range 1..15.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; must be faster than 4x the ripple source clock.
- reset  input  1  asynchronous, active-high; clears all state.
- cnt_in  input  W  raw ripple counter bits; asynchronous to clk; may glitch.
- dir_up  input  1  expected direction: 0 = down (-1 per step), 1 = up (+1 per step). Quasi-static.
- count_out  output  W  last committed count.
- count_valid  output  1  one-cycle pulse when count_out updates.
- wrap  output  1  one-cycle pulse, coincident with count_valid, on a terminal wrap.
- step_err  output  1  one-cycle pulse, coincident with count_valid, when a commit violates the expected ±1 step.
- err_cnt  output  ERR_CNT_W  number of step errors; saturating.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high (`reset`).
- Reset values:
  - All outputs 0.
  - Synchronizer flops 0, candidate register 0, stability counter 0.
  - FSM in IDLE.
  - Flag `primed` = 0.
- Synchronizer: 2-FF per bit. `sync_q` is cnt_in delayed 2 edges.
- FSM is IDLE / SETTLE, evaluated every edge:
  - **IDLE:** if `sync_q != count_out`: load `cand <= sync_q`, `stab <= 0`, go to SETTLE. Otherwise stay.
  - **SETTLE, `sync_q != cand`:** reload `cand <= sync_q` and `stab <= 0`; stay in SETTLE.
  - **SETTLE, `sync_q == cand`, `stab < STABLE_CYCLES-1`:** `stab++`.
  - **SETTLE, `sync_q == cand`, `stab == STABLE_CYCLES-1`:** commit, go to IDLE.
  - **SETTLE, `cand == count_out`:** a glitch returned to the committed value. Go to IDLE with no commit and no pulse.
- Commit, all in the same edge:
  - `count_out <= cand` and `count_valid <= 1`.
  - Step check and wrap evaluation use the old count_out.
  - Set `primed <= 1`.
- Latency:
  - Let E0 be the first edge that samples a new settled cnt_in.
  - count_valid is high in the cycle after edge E0+2+STABLE_CYCLES, i.e. E0+4 with the default.
  - It lasts exactly one cycle.
- Expected step: `exp = dir_up ? old+1 : old-1`, modulo 2^W.
- wrap:
  - dir_up=0: asserted when old==0 and new==2^W-1.
  - dir_up=1: asserted when old==2^W-1 and new==0.
  - A wrap is not an error.
- step_err:
  - Asserted when `primed==1 && new != exp`.
  - The first commit after reset is never checked.
- err_cnt increments on each step_err and holds at all-ones.
- Asynchronous reset mid-SETTLE: pending candidate discarded; no pulse.
- A dir_up change takes effect at the next commit.

Optional Feature:
- Macro: RCM_STEP_CHECK_EN.
- Defined: step checker, step_err and err_cnt behave as specified above.
- Undefined:
  - Checker logic is removed; step_err and err_cnt are tied to 0.
  - count_out, count_valid and wrap are unchanged.

Decomposition:
- Shared package `ripple_count_pkg` holds:
  - FSM state typedef (IDLE, SETTLE).
  - Default width constants (W=3, STABLE_CYCLES=2, ERR_CNT_W=8).
- Sub-module `sync_2ff`:
  - Parameterised W-bit two-flop synchronizer with async active-high reset.
  - Instantiated once.

Test Plan:
- **Reset and first commit:** Hold reset, then release with cnt_in=0 → all outputs 0, no count_valid. Then drive cnt_in=7 stable → count_valid at E0+4, count_out=7, wrap=0, step_err=0 (unprimed).
- **Clean down sequence (dir_up=0):** cnt_in sequence 7,6,5,…,0,7, each held 8 clk cycles → one count_valid per value. wrap=1 only on 0→7. step_err never set. err_cnt=0.
- **Ripple glitch rejection:** cnt_in 4→(5 for 1 clk)→3 → single commit count_out=3. No commit of 5. step_err=0.
- **Glitch back to committed value:** count_out=2; cnt_in pulses to 6 for 1 clk and returns to 2 → no count_valid, count_out stays 2.
- **Step errors and saturation:** dir_up=0, primed; jump 5→2 → step_err pulse, err_cnt=1. With ERR_CNT_W=2, force 5 errors → err_cnt stays 3.
- **Reset mid-settle:** change cnt_in, assert reset at E0+3 → no count_valid; after release all outputs 0 and primed=0.
